// File: rtl/t05_htree_decode_if.sv
// Bus bundle for the Huffman tree decoder: SRAM node read port,
// encoded bit input handshake and decoded character output handshake.
interface t05_htree_decode_if;
    // SRAM node read port
    logic        node_rd_req;
    logic [6:0]  node_addr;
    logic [70:0] node_data;
    logic        node_rd_done;
    // encoded bitstream in
    logic        bit_in;
    logic        bit_valid;
    logic        bit_ready;
    // decoded characters out
    logic [7:0]  char_out;
    logic        char_valid;
    logic        char_ready;

    // decoder side
    modport master (
        output node_rd_req, node_addr, bit_ready, char_out, char_valid,
        input  node_data, node_rd_done, bit_in, bit_valid, char_ready
    );

    // environment side (SRAM, bit source, character sink)
    modport slave (
        input  node_rd_req, node_addr, bit_ready, char_out, char_valid,
        output node_data, node_rd_done, bit_in, bit_valid, char_ready
    );
endinterface

// File: rtl/t05_htree_decode.sv
// Huffman tree decoder: walks a tree stored in SRAM one encoded bit at a
// time and emits a character every time a leaf is reached. The root's
// child pointers are cached so each new symbol restarts without an SRAM read.
module t05_htree_decode (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        HD_en,
    input  logic [6:0]                  root_index,
    t05_htree_decode_if.master          bus,
    output logic                        HD_finished,
    output logic                        ERROR,
    output logic [2:0]                  state_reg
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ROOT  = 3'd1,
        WAIT_BIT = 3'd2,
        RD_NODE  = 3'd3,
        EMIT     = 3'd4,
        FIN      = 3'd5,
        ERR      = 3'd6
    } state_t;

    localparam logic [8:0] NULL_CHILD = 9'h180;
    localparam logic [6:0] HOP_LIMIT  = 7'd127;

    state_t       state_q, state_d;
    // Only the child pointers of a node are needed for traversal, so the
    // root cache and current node hold {left, right} and nothing else.
    logic [17:0]  root_q, root_d;
    logic [17:0]  cur_q, cur_d;
    logic [45:0]  target_q, target_d;
    logic [45:0]  char_cnt_q, char_cnt_d;
    logic [6:0]   hop_q, hop_d;
    logic [6:0]   addr_q, addr_d;
    logic [7:0]   char_q, char_d;

    logic [8:0]   child;
    logic [45:0]  cnt_inc;
    logic [6:0]   hop_inc;

    // Next-state and datapath updates; HD_en low always wins and parks in IDLE.
    always_comb begin
        state_d    = state_q;
        root_d     = root_q;
        cur_d      = cur_q;
        target_d   = target_q;
        char_cnt_d = char_cnt_q;
        hop_d      = hop_q;
        addr_d     = addr_q;
        char_d     = char_q;
        child      = bus.bit_in ? cur_q[8:0] : cur_q[17:9];
        cnt_inc    = char_cnt_q + 46'd1;
        hop_inc    = hop_q + 7'd1;

        if (!HD_en) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = RD_ROOT;
                end
                RD_ROOT: begin
                    if (bus.node_rd_done) begin
                        root_d   = bus.node_data[63:46];
                        cur_d    = bus.node_data[63:46];
                        target_d = bus.node_data[45:0];
                        state_d  = (bus.node_data[45:0] == 46'd0) ? FIN : WAIT_BIT;
                    end
                end
                WAIT_BIT: begin
                    if (bus.bit_valid) begin
                        if (child == NULL_CHILD) begin
                            state_d = ERR;
                        end else if (child[8]) begin
                            addr_d  = child[6:0];
                            state_d = RD_NODE;
                        end else begin
                            char_d  = child[7:0];
                            hop_d   = 7'd0;
                            state_d = EMIT;
                        end
                    end
                end
                RD_NODE: begin
                    if (bus.node_rd_done) begin
                        if (bus.node_data[70:64] != addr_q) begin
                            state_d = ERR;
                        end else if (hop_inc == HOP_LIMIT) begin
                            // a well-formed tree can never be this deep: treat as a loop
                            hop_d   = hop_inc;
                            state_d = ERR;
                        end else begin
                            cur_d   = bus.node_data[63:46];
                            hop_d   = hop_inc;
                            state_d = WAIT_BIT;
                        end
                    end
                end
                EMIT: begin
                    if (bus.char_ready) begin
                        char_cnt_d = cnt_inc;
                        if (cnt_inc == target_q) begin
                            state_d = FIN;
                        end else begin
                            cur_d   = root_q;
                            state_d = WAIT_BIT;
                        end
                    end
                end
                FIN:     state_d = FIN;
                ERR:     state_d = ERR;
                default: state_d = IDLE;
            endcase
        end

        // every decode run starts with fresh counters
        if (state_q == IDLE) begin
            char_cnt_d = 46'd0;
            hop_d      = 7'd0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            root_q     <= '0;
            cur_q      <= '0;
            target_q   <= '0;
            char_cnt_q <= '0;
            hop_q      <= '0;
            addr_q     <= '0;
            char_q     <= '0;
        end else begin
            state_q    <= state_d;
            root_q     <= root_d;
            cur_q      <= cur_d;
            target_q   <= target_d;
            char_cnt_q <= char_cnt_d;
            hop_q      <= hop_d;
            addr_q     <= addr_d;
            char_q     <= char_d;
        end
    end

    // Handshake and status outputs come straight from the registered state.
    assign bus.node_rd_req = (state_q == RD_ROOT) || (state_q == RD_NODE);
    assign bus.node_addr   = (state_q == RD_ROOT) ? root_index : addr_q;
    assign bus.bit_ready   = (state_q == WAIT_BIT);
    assign bus.char_valid  = (state_q == EMIT);
    assign bus.char_out    = char_q;
    assign HD_finished     = (state_q == FIN);
    assign ERROR           = (state_q == ERR);
    assign state_reg       = state_q;

endmodule

// File: tb/tb_t05_htree_decode.sv
// Scoreboard bench for the Huffman tree decoder: directed trees and bit
// sequences, expected characters queued up front and checked by a monitor.
module tb_t05_htree_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        HD_en;
    logic [6:0]  root_index;
    logic        HD_finished;
    logic        ERROR;
    logic [2:0]  state_reg;

    t05_htree_decode_if bus ();

    t05_htree_decode dut (
        .clk         (clk),
        .rst         (rst),
        .HD_en       (HD_en),
        .root_index  (root_index),
        .bus         (bus.master),
        .HD_finished (HD_finished),
        .ERROR       (ERROR),
        .state_reg   (state_reg)
    );

    always #5 clk = ~clk;

    logic [70:0] mem [0:127];
    int          rd_count [0:127];
    bit          bitq [$];
    logic [7:0]  expq [$];
    int          checks = 0;
    int          errors = 0;
    int          stall_cfg = 0;
    int          chars_seen = 0;
    bit          bready_seen = 1'b0;

    function automatic logic [70:0] mk_node(input logic [6:0] idx, input logic [8:0] l,
                                            input logic [8:0] r, input logic [45:0] s);
        return {idx, l, r, s};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // SRAM model: answers a request two cycles later with a one-cycle done pulse
    initial begin : sram
        int lat;
        lat = 0;
        bus.node_rd_done = 1'b0;
        bus.node_data    = '0;
        forever begin
            @(negedge clk);
            if (bus.node_rd_done) begin
                bus.node_rd_done = 1'b0;
            end else if (bus.node_rd_req) begin
                lat++;
                if (lat >= 2) begin
                    lat = 0;
                    bus.node_data    = mem[bus.node_addr];
                    bus.node_rd_done = 1'b1;
                    rd_count[bus.node_addr]++;
                end
            end else begin
                lat = 0;
            end
        end
    end

    // Bit source: presents the head of bitq, pops it once the handshake lands
    initial begin : bitsrc
        bit pend;
        pend = 1'b0;
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b0;
        forever begin
            @(negedge clk);
            if (pend && bitq.size() > 0) void'(bitq.pop_front());
            pend = 1'b0;
            if (bus.bit_ready) bready_seen = 1'b1;
            if (bitq.size() > 0) begin
                bus.bit_valid = 1'b1;
                bus.bit_in    = bitq[0];
            end else begin
                bus.bit_valid = 1'b0;
            end
            if (bus.bit_valid && bus.bit_ready && HD_en && !rst) pend = 1'b1;
        end
    end

    // Character monitor: optional stall, then pop expected value and compare
    initial begin : monitor
        int stall_left;
        stall_left = 0;
        bus.char_ready = 1'b0;
        forever begin
            @(negedge clk);
            bus.char_ready = 1'b0;
            if (bus.char_valid && HD_en && !rst) begin
                check("bit_ready_low_in_emit", bus.bit_ready, 1'b0);
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_char: got %0h expected none", bus.char_out);
                    bus.char_ready = 1'b1;
                end else if (stall_left > 0) begin
                    stall_left--;
                    check("char_stable", bus.char_out, expq[0]);
                end else begin
                    bus.char_ready = 1'b1;
                    check("char", bus.char_out, expq.pop_front());
                    chars_seen++;
                end
            end else begin
                stall_left = stall_cfg;
            end
        end
    end

    task automatic start(input logic [6:0] root);
        HD_en = 1'b0;
        cyc(2);
        check("idle_after_disable", state_reg, 3'd0);
        for (int i = 0; i < 128; i++) rd_count[i] = 0;
        root_index = root;
        HD_en = 1'b1;
    endtask

    task automatic wait_end(input string name, input bit want_err);
        for (int i = 0; i < 400 && !(HD_finished || ERROR); i++) cyc(1);
        check({name, "_finished"}, HD_finished, !want_err);
        check({name, "_error"}, ERROR, want_err);
    endtask

    initial begin : main
        int c0;
        rst = 1'b1;
        HD_en = 1'b0;
        root_index = 7'd0;
        for (int i = 0; i < 128; i++) begin
            mem[i] = '0;
            rd_count[i] = 0;
        end
        cyc(3);
        check("rst_state", state_reg, 3'd0);
        check("rst_rd_req", bus.node_rd_req, 1'b0);
        check("rst_addr", bus.node_addr, 7'd0);
        check("rst_bit_ready", bus.bit_ready, 1'b0);
        check("rst_char_valid", bus.char_valid, 1'b0);
        check("rst_char_out", bus.char_out, 8'd0);
        check("rst_fin_err", {HD_finished, ERROR}, 2'b00);
        rst = 1'b0;

        // three-symbol tree: bits 1,0,0,0,1 -> A B C
        mem[2] = mk_node(7'd2, 9'h101, 9'h041, 46'd3);
        mem[1] = mk_node(7'd1, 9'h042, 9'h043, 46'd2);
        stall_cfg = 0;
        expq = '{8'h41, 8'h42, 8'h43};
        bitq = '{1, 0, 0, 0, 1};
        start(7'd2);
        wait_end("abc", 1'b0);
        check("abc_reads_root", rd_count[2], 1);
        check("abc_reads_node1", rd_count[1], 2);
        check("abc_exp_left", expq.size(), 0);
        check("abc_state_fin", state_reg, 3'd5);
        HD_en = 1'b0;
        cyc(1);
        check("abc_disable_idle", state_reg, 3'd0);
        check("abc_fin_drop", HD_finished, 1'b0);

        // same tree with a five-cycle consumer stall on every character
        stall_cfg = 5;
        expq = '{8'h41, 8'h42, 8'h43};
        bitq = '{1, 0, 0, 0, 1};
        start(7'd2);
        wait_end("stall", 1'b0);
        check("stall_exp_left", expq.size(), 0);
        check("stall_bits_left", bitq.size(), 0);
        stall_cfg = 0;

        // single-char tree: A, then the null child is an error
        mem[0] = mk_node(7'd0, 9'h041, 9'h180, 46'd2);
        c0 = chars_seen;
        expq = '{8'h41};
        bitq = '{0, 1};
        start(7'd0);
        wait_end("null", 1'b1);
        check("null_chars", chars_seen - c0, 1);
        HD_en = 1'b0;
        cyc(1);
        check("err_disable_idle", state_reg, 3'd0);
        check("err_drop", ERROR, 1'b0);

        // node read returns the wrong index
        mem[1] = mk_node(7'd5, 9'h042, 9'h043, 46'd2);
        c0 = chars_seen;
        bitq = '{0};
        start(7'd2);
        wait_end("badidx", 1'b1);
        check("badidx_chars", chars_seen - c0, 0);

        // reset in the middle of a node read, then a full restart
        mem[1] = mk_node(7'd1, 9'h042, 9'h043, 46'd2);
        expq = '{8'h41};
        bitq = '{1, 0};
        start(7'd2);
        for (int i = 0; i < 200 && !(state_reg == 3'd3 && bus.node_rd_req); i++) cyc(1);
        check("mid_in_rd_node", state_reg, 3'd3);
        rst = 1'b1;
        cyc(1);
        check("mid_rst_state", state_reg, 3'd0);
        check("mid_rst_req", bus.node_rd_req, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 50 && !bus.node_rd_req; i++) cyc(1);
        check("restart_req", bus.node_rd_req, 1'b1);
        check("restart_addr", bus.node_addr, 7'd2);
        expq = '{8'h41, 8'h42, 8'h43};
        bitq = '{1, 0, 0, 0, 1};
        wait_end("restart", 1'b0);
        check("restart_exp_left", expq.size(), 0);

        // empty message: root sum zero finishes without asking for a bit
        mem[3] = mk_node(7'd3, 9'h041, 9'h042, 46'd0);
        start(7'd3);
        bready_seen = 1'b0;
        wait_end("empty", 1'b0);
        cyc(2);
        check("empty_no_bit_ready", bready_seen, 1'b0);
        check("empty_reads", rd_count[3], 1);

        HD_en = 1'b0;
        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end

endmodule
